// File: rtl/rv_pipe_pkg.sv
// Shared types for the RV32I pipeline sequencer.
// FSM states, register index width, NOP word, control bundle.
package rv_pipe_pkg;

  localparam int REG_IDX_W = 5;
  localparam logic [31:0] NOP = 32'h00000013;

  typedef enum logic {
    RUN,
    MC_WAIT
  } state_t;

  typedef struct packed {
    logic pc_en;
    logic ifid_en;
    logic idex_en;
    logic ifid_flush;
    logic idex_flush;
    logic exmem_bubble;
    logic mc_done;
  } ctrl_t;

  localparam ctrl_t C_RUN   = '{1'b1, 1'b1, 1'b1,
                                1'b0, 1'b0, 1'b0, 1'b0};
  localparam ctrl_t C_BR    = '{1'b1, 1'b1, 1'b1,
                                1'b1, 1'b1, 1'b0, 1'b0};
  localparam ctrl_t C_LU    = '{1'b0, 1'b0, 1'b1,
                                1'b0, 1'b1, 1'b0, 1'b0};
  localparam ctrl_t C_MC    = '{1'b0, 1'b0, 1'b0,
                                1'b0, 1'b0, 1'b1, 1'b0};
  localparam ctrl_t C_DONE  = '{1'b1, 1'b1, 1'b1,
                                1'b0, 1'b0, 1'b0, 1'b1};
  localparam ctrl_t C_RESET = '{1'b0, 1'b0, 1'b0,
                                1'b1, 1'b1, 1'b1, 1'b0};

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter for pipeline perf events.
// Holds at all-ones instead of wrapping.
module sat_counter #(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             inc,
  output logic [CNT_W-1:0] cnt
);

  // count up on inc, stick at all-ones
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (inc && (cnt != '1)) begin
      cnt <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline sequencer: branch flush, load-use stall,
// multi-cycle EX hold, stall/flush perf counters.
module hazard_ctrl
  import rv_pipe_pkg::*;
#(
  parameter int MC_CYCLES = 4,
  parameter int CNT_W     = 32
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 id_valid,
  input  logic [REG_IDX_W-1:0] id_rs1,
  input  logic [REG_IDX_W-1:0] id_rs2,
  input  logic                 id_uses_rs1,
  input  logic                 id_uses_rs2,
  input  logic                 ex_valid,
  input  logic [REG_IDX_W-1:0] ex_rd,
  input  logic                 ex_mem_read,
  input  logic                 ex_branch_taken,
  input  logic                 ex_mc_start,
  output logic                 pc_en,
  output logic                 ifid_en,
  output logic                 idex_en,
  output logic                 ifid_flush,
  output logic                 idex_flush,
  output logic                 exmem_bubble,
  output logic                 mc_done,
  output logic                 busy,
  output logic [CNT_W-1:0]     stall_cnt,
  output logic [CNT_W-1:0]     flush_cnt
);

  localparam int  CW    = $clog2(MC_CYCLES) + 1;
  localparam bit  MC_OK = (MC_CYCLES >= 2);
  localparam logic [CW-1:0] MC_LOAD =
    CW'(MC_CYCLES - 1);
  localparam logic [CW-1:0] ONE = CW'(1);

  state_t        state;
  logic [CW-1:0] mc_cnt;
  ctrl_t         core;
  ctrl_t         ctrl;
  logic          run;
  logic          br;
  logic          mc;
  logic          lu;
  logic          rs1_hit;
  logic          rs2_hit;
  logic          mc_go;

  assign run = (state == RUN);
  assign br  = ex_valid & ex_branch_taken;
  assign mc  = ex_valid & ex_mc_start & MC_OK;

  assign rs1_hit = id_uses_rs1 & (id_rs1 == ex_rd);
  assign rs2_hit = id_uses_rs2 & (id_rs2 == ex_rd);
  assign lu = ex_valid & ex_mem_read &
              (ex_rd != '0) & id_valid &
              (rs1_hit | rs2_hit);

  assign mc_go = run & ~br & mc;

  // priority decode, made one-hot by masking
  always_comb begin
    core = C_RUN;
    unique case (1'b1)
      (!run && mc_cnt >  ONE): core = C_MC;
      (!run && mc_cnt == ONE): core = C_DONE;
      (run && br):             core = C_BR;
      (run && !br && mc):      core = C_MC;
      (run && !br && !mc && lu): core = C_LU;
      default:                 core = C_RUN;
    endcase
  end

  // reset overrides the decode while rst_n is low
  always_comb begin
    ctrl = core;
    if (!rst_n) begin
      ctrl = C_RESET;
    end
  end

  assign pc_en        = ctrl.pc_en;
  assign ifid_en      = ctrl.ifid_en;
  assign idex_en      = ctrl.idex_en;
  assign ifid_flush   = ctrl.ifid_flush;
  assign idex_flush   = ctrl.idex_flush;
  assign exmem_bubble = ctrl.exmem_bubble;
  assign mc_done      = ctrl.mc_done;
  assign busy         = rst_n & ~run;

  // RUN/MC_WAIT sequencing and EX occupancy count
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= RUN;
      mc_cnt <= '0;
    end else begin
      unique case (state)
        RUN: begin
          if (mc_go) begin
            state  <= MC_WAIT;
            mc_cnt <= MC_LOAD;
          end
        end
        MC_WAIT: begin
          mc_cnt <= mc_cnt - ONE;
          if (mc_cnt <= ONE) begin
            state <= RUN;
          end
        end
        default: begin
          state  <= RUN;
          mc_cnt <= '0;
        end
      endcase
    end
  end

  sat_counter #(.CNT_W(CNT_W)) u_stall (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (~core.pc_en),
    .cnt   (stall_cnt)
  );

  sat_counter #(.CNT_W(CNT_W)) u_flush (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (run & br),
    .cnt   (flush_cnt)
  );

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed bench for hazard_ctrl.
// Second instance with CNT_W=4 for saturation.
module tb_hazard_ctrl;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       id_valid;
  logic [4:0] id_rs1, id_rs2;
  logic       id_uses_rs1, id_uses_rs2;
  logic       ex_valid;
  logic [4:0] ex_rd;
  logic       ex_mem_read;
  logic       ex_branch_taken;
  logic       ex_mc_start;

  logic pc_en, ifid_en, idex_en;
  logic ifid_flush, idex_flush;
  logic exmem_bubble, mc_done, busy;
  logic [31:0] stall_cnt, flush_cnt;

  logic s_pc_en, s_ifid_en, s_idex_en;
  logic s_ifid_flush, s_idex_flush;
  logic s_exmem_bubble, s_mc_done, s_busy;
  logic [3:0] s_stall_cnt, s_flush_cnt;

  logic [6:0] ov;

  localparam logic [6:0] V_RUN  = 7'b1110000;
  localparam logic [6:0] V_BR   = 7'b1111100;
  localparam logic [6:0] V_LU   = 7'b0010100;
  localparam logic [6:0] V_MC   = 7'b0000010;
  localparam logic [6:0] V_DONE = 7'b1110001;
  localparam logic [6:0] V_RST  = 7'b0001110;

  int n_cmp = 0;
  int n_err = 0;

  assign ov = {pc_en, ifid_en, idex_en, ifid_flush,
               idex_flush, exmem_bubble, mc_done};

  always #5 clk = ~clk;

  hazard_ctrl #(.MC_CYCLES(4), .CNT_W(32)) u_dut (
    .clk(clk), .rst_n(rst_n),
    .id_valid(id_valid),
    .id_rs1(id_rs1), .id_rs2(id_rs2),
    .id_uses_rs1(id_uses_rs1),
    .id_uses_rs2(id_uses_rs2),
    .ex_valid(ex_valid), .ex_rd(ex_rd),
    .ex_mem_read(ex_mem_read),
    .ex_branch_taken(ex_branch_taken),
    .ex_mc_start(ex_mc_start),
    .pc_en(pc_en), .ifid_en(ifid_en),
    .idex_en(idex_en),
    .ifid_flush(ifid_flush),
    .idex_flush(idex_flush),
    .exmem_bubble(exmem_bubble),
    .mc_done(mc_done), .busy(busy),
    .stall_cnt(stall_cnt),
    .flush_cnt(flush_cnt)
  );

  hazard_ctrl #(.MC_CYCLES(4), .CNT_W(4)) u_sat (
    .clk(clk), .rst_n(rst_n),
    .id_valid(id_valid),
    .id_rs1(id_rs1), .id_rs2(id_rs2),
    .id_uses_rs1(id_uses_rs1),
    .id_uses_rs2(id_uses_rs2),
    .ex_valid(ex_valid), .ex_rd(ex_rd),
    .ex_mem_read(ex_mem_read),
    .ex_branch_taken(ex_branch_taken),
    .ex_mc_start(ex_mc_start),
    .pc_en(s_pc_en), .ifid_en(s_ifid_en),
    .idex_en(s_idex_en),
    .ifid_flush(s_ifid_flush),
    .idex_flush(s_idex_flush),
    .exmem_bubble(s_exmem_bubble),
    .mc_done(s_mc_done), .busy(s_busy),
    .stall_cnt(s_stall_cnt),
    .flush_cnt(s_flush_cnt)
  );

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h want %0h",
               tag, got, exp);
    end
  endtask

  task automatic idle();
    id_valid = 0; id_rs1 = 0; id_rs2 = 0;
    id_uses_rs1 = 0; id_uses_rs2 = 0;
    ex_valid = 0; ex_rd = 0; ex_mem_read = 0;
    ex_branch_taken = 0; ex_mc_start = 0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    idle();
    rst_n = 0;
    tick();
    tick();
    rst_n = 1;
    #1;
  endtask

  task automatic set_lu(input logic [4:0] rd,
                        input logic [4:0] rs1,
                        input logic u1);
    idle();
    ex_valid = 1; ex_mem_read = 1; ex_rd = rd;
    id_valid = 1; id_rs1 = rs1; id_uses_rs1 = u1;
  endtask

  logic [6:0] b2b [8];

  initial begin
    idle();
    rst_n = 0;
    #12;
    chk("rst_ctrl", 32'(ov), 32'(V_RST));
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_stall", stall_cnt, 32'd0);
    chk("rst_flush", flush_cnt, 32'd0);
    tick();
    rst_n = 1;
    #1;
    chk("idle_ctrl", 32'(ov), 32'(V_RUN));

    // load-use on rs1
    set_lu(5'd5, 5'd5, 1'b1);
    #1;
    chk("lu_rs1", 32'(ov), 32'(V_LU));
    tick();
    chk("lu_cnt1", stall_cnt, 32'd1);
    idle();
    #1;
    chk("lu_after", 32'(ov), 32'(V_RUN));
    // x0 destination never stalls
    set_lu(5'd0, 5'd0, 1'b1);
    #1;
    chk("lu_x0", 32'(ov), 32'(V_RUN));
    tick();
    chk("lu_x0_cnt", stall_cnt, 32'd1);
    // match on rs1 but rs1 unused
    set_lu(5'd9, 5'd9, 1'b0);
    #1;
    chk("lu_unused", 32'(ov), 32'(V_RUN));
    // hazard through rs2
    id_rs2 = 5'd9; id_uses_rs2 = 1;
    #1;
    chk("lu_rs2", 32'(ov), 32'(V_LU));
    tick();
    chk("lu_cnt2", stall_cnt, 32'd2);

    // branch wins over load-use
    set_lu(5'd5, 5'd5, 1'b1);
    ex_branch_taken = 1;
    #1;
    chk("br_lu", 32'(ov), 32'(V_BR));
    tick();
    chk("br_flush", flush_cnt, 32'd1);
    chk("br_stall", stall_cnt, 32'd2);

    // multi-cycle op, 4 EX cycles
    do_reset();
    ex_valid = 1; ex_mc_start = 1;
    #1;
    chk("mc_c0", 32'(ov), 32'(V_MC));
    chk("mc_c0_busy", 32'(busy), 32'd0);
    tick();
    ex_branch_taken = 1;
    #1;
    chk("mc_c1", 32'(ov), 32'(V_MC));
    chk("mc_c1_busy", 32'(busy), 32'd1);
    tick();
    chk("mc_c2", 32'(ov), 32'(V_MC));
    tick();
    chk("mc_c3", 32'(ov), 32'(V_DONE));
    chk("mc_c3_busy", 32'(busy), 32'd1);
    chk("mc_stall", stall_cnt, 32'd3);
    idle();
    tick();
    chk("mc_end_busy", 32'(busy), 32'd0);
    chk("mc_end_flush", flush_cnt, 32'd0);
    chk("mc_end_ctrl", 32'(ov), 32'(V_RUN));

    // reset aborts MC_WAIT
    do_reset();
    ex_valid = 1; ex_mc_start = 1;
    tick();
    tick();
    idle();
    #1;
    chk("ab_pre_busy", 32'(busy), 32'd1);
    rst_n = 0;
    #1;
    chk("ab_ctrl", 32'(ov), 32'(V_RST));
    chk("ab_busy", 32'(busy), 32'd0);
    chk("ab_stall", stall_cnt, 32'd0);
    tick();
    rst_n = 1;
    #1;
    chk("ab_run", 32'(ov), 32'(V_RUN));
    tick();
    chk("ab_nodone", 32'(ov), 32'(V_RUN));
    chk("ab_idle", 32'(busy), 32'd0);

    // saturation with CNT_W=4
    do_reset();
    set_lu(5'd3, 5'd3, 1'b1);
    for (int i = 0; i < 14; i++) tick();
    chk("sat_e", 32'(s_stall_cnt), 32'hE);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("sat_f", 32'(s_stall_cnt), 32'hF);
    end
    chk("sat_wide", stall_cnt, 32'd17);

    // back-to-back multi-cycle ops
    do_reset();
    b2b = '{V_MC, V_MC, V_MC, V_DONE,
            V_MC, V_MC, V_MC, V_DONE};
    ex_valid = 1; ex_mc_start = 1;
    for (int i = 0; i < 8; i++) begin
      #1;
      chk($sformatf("b2b_%0d", i),
          32'(ov), 32'(b2b[i]));
      tick();
    end
    idle();
    #1;
    chk("b2b_stall", stall_cnt, 32'd6);
    chk("b2b_busy", 32'(busy), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_err);
    $finish;
  end

endmodule
